uart_tx_pbuf: RTL and testbench
===============================

UART_TX_PBUF -- requirements
Module: uart_tx_pbuf

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal 5..8.
REQ-002 Parameter DEPTH, default 16, FIFO entries, power of two, >=2.
REQ-003 Parameter CLKS_PER_BIT, default 4, clock cycles per UART bit, >=1.
REQ-004 Parameter AF_THRESH, default DEPTH-2, almost_full threshold in entries.
REQ-005 clk_3125  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  push request.
REQ-008 wr_data  in  DATA_W  word to queue.
REQ-009 parity_en  in  1  1 = append parity bit.
REQ-010 parity_type  in  1  0 = even, 1 = odd.
REQ-011 two_stop  in  1  1 = two stop bits, 0 = one.
REQ-012 ovf_clr  in  1  clears overflow.
REQ-013 tx  out  1  serial line, idle high.
REQ-014 busy  out  1  frame in progress.
REQ-015 tx_done  out  1  one-cycle pulse per completed frame.
REQ-016 full, empty, almost_full  out  1 each  FIFO status.
REQ-017 count  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH.
REQ-018 overflow  out  1  sticky dropped-write flag.

Function
REQ-019 A write is accepted when wr_en=1 and full=0, judged on pre-edge state; an accepted word is poppable from the next cycle.
REQ-020 wr_en=1 while full=1 drops the word, leaves FIFO unchanged, sets overflow; a pop on the same edge does not rescue the write.
REQ-021 overflow clears on ovf_clr=1; if ovf_clr and a new overflow coincide, overflow stays 1.
REQ-022 A simultaneous accepted write and pop leaves count unchanged; pointers wrap modulo DEPTH.
REQ-023 full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), all registered-consistent with count.
REQ-024 FSM states IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE with empty=0: pop head word, latch word, parity_en, parity_type, two_stop, go to START; latched config governs the whole frame, so input changes mid-frame are ignored.
REQ-026 Each bit holds tx for exactly CLKS_PER_BIT cycles: START drives 0, DATA drives LSB first for DATA_W bits, PARITY (only if parity_en latched) drives XOR of data for even or XNOR for odd, STOP drives 1 for 1 or 2 bit times.
REQ-027 Frame length = (1 + DATA_W + parity_en + 1 + two_stop) * CLKS_PER_BIT cycles.
REQ-028 tx_done pulses high in the last cycle of the final stop bit.
REQ-029 In that same cycle, if empty=0 the FSM pops and goes directly to START (zero idle gap between frames), otherwise it goes to IDLE.
REQ-030 Latency: a word written into an empty FIFO with the FSM in IDLE drives tx low 2 cycles after the write edge.
REQ-031 busy=1 in all states except IDLE.
REQ-032 tx is registered; no glitches.

Reset
REQ-033 reset=0 asynchronously forces tx=1, busy=0, tx_done=0, count=0, empty=1, full=0, almost_full=0, overflow=0, pointers=0, FSM=IDLE.
REQ-034 Reset mid-frame aborts the frame and discards queued words; after release, no frame starts until a new write is accepted.

Verification
REQ-035 Defaults; write 0xA5, parity_en=1, parity_type=0, two_stop=0 -> tx = 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; 44-cycle frame; single tx_done pulse.
REQ-036 Write 0x01, parity_type=1, two_stop=1 -> bits 0,1,0x7,0(parity),1,1; 48 cycles.
REQ-037 18 back-to-back writes 0x00..0x11 from idle -> 0x11 dropped, overflow=1, full=1 after the 17th write edge; frames 0x00..0x10 sent with no idle gap; ovf_clr -> overflow=0.
REQ-038 parity_en=0, write 0xFF, toggle parity_en/two_stop mid-frame -> 10-bit, 40-cycle frame unaffected.
REQ-039 Queue 5 words, assert reset during data bit 3 -> tx=1 immediately, count=0, empty=1; after release tx stays 1.
REQ-040 Simultaneous write and pop at count=DEPTH-1 -> count stays DEPTH-1, data order preserved across pointer wrap.

Source files
------------

// File: rtl/uart_tx_pbuf.sv
// rtl/uart_tx_pbuf.sv - UART transmitter fed by a parameterised write FIFO
// Outputs are registered from the current FSM state, so tx trails the state by one cycle.
module uart_tx_pbuf #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int AF_THRESH    = DEPTH - 2
) (
  input  logic                       clk_3125,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       parity_en,
  input  logic                       parity_type,
  input  logic                       two_stop,
  input  logic                       ovf_clr,
  output logic                       tx,
  output logic                       busy,
  output logic                       tx_done,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic              overflow_q, overflow_d;
  logic [2:0]        state_q, state_d;
  logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d, two_stop_q, two_stop_d;
  logic              tx_q, tx_d, busy_q, busy_d, tx_done_q, tx_done_d;
  logic              wr_accept, pop, bit_end, frame_end;
  logic [DATA_W-1:0] head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    wr_accept = wr_en & ~full_q;
    bit_end   = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));
    frame_end = (state_q == STOP) && bit_end && (bit_cnt_q == {3'b000, two_stop_q});
    // Popping at the final stop cycle gives back-to-back frames with no idle gap.
    pop       = ~empty_q & ((state_q == IDLE) | frame_end);

    wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
    af_d    = (count_d >= CW'(AF_THRESH));

    if (wr_en && full_q)
      overflow_d = 1'b1;
    else if (ovf_clr)
      overflow_d = 1'b0;
    else
      overflow_d = overflow_q;
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;

    if (pop) begin
      state_d    = START;
      clk_cnt_d  = '0;
      bit_cnt_d  = '0;
      shreg_d    = head;
      par_en_d   = parity_en;
      par_bit_d  = (^head) ^ parity_type;
      two_stop_d = two_stop;
    end else begin
      case (state_q)
        START: begin
          if (bit_end) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            clk_cnt_d = clk_cnt_q + CLK_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_d = '0;
            shreg_d   = shreg_q >> 1;
            if (bit_cnt_q == 4'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CLK_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            clk_cnt_d = clk_cnt_q + CLK_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt_d = '0;
            if (frame_end)
              state_d = IDLE;
            else
              bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            clk_cnt_d = clk_cnt_q + CLK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
    busy_d    = (state_q != IDLE);
    tx_done_d = frame_end;
  end

  always_ff @(posedge clk_3125) begin
    if (wr_accept)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_3125 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign tx_done     = tx_done_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_pbuf.sv
// tb/tb_uart_tx_pbuf.sv - randomized and directed checks of uart_tx_pbuf against a frame-level model
module tb_uart_tx_pbuf;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int AFT   = DEPTH - 2;

  logic       clk_3125 = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, parity_en = 1'b0, parity_type = 1'b0, two_stop = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx, busy, tx_done, full, empty, almost_full, overflow;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_pbuf #(.DATA_W(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .AF_THRESH(AFT)) dut (
    .clk_3125(clk_3125), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .parity_en(parity_en), .parity_type(parity_type), .two_stop(two_stop), .ovf_clr(ovf_clr),
    .tx(tx), .busy(busy), .tx_done(tx_done), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  always #5 clk_3125 = ~clk_3125;

  // Model: a queue of words plus the serial image of the current and previous frame.
  // A pop happens on the first edge at which the line is free and the queue holds a word.
  logic [7:0]  m_q[$];
  logic        m_ovf = 1'b0;
  int          cyc = 0, free_at = 0;
  int          cur_s = -1000, cur_l = 0, prv_s = -1000, prv_l = 0;
  logic [0:11] cur_b = '1, prv_b = '1;
  logic        m_pop, m_acc;
  logic [7:0]  m_w;
  logic [0:11] m_b;
  int          m_nb;

  initial forever begin
    @(posedge clk_3125);
    cyc++;
    if (!reset) begin
      m_q.delete();
      m_ovf   = 1'b0;
      free_at = cyc;
      cur_s   = -1000;
      prv_s   = -1000;
    end else begin
      m_pop = (cyc >= free_at) && (m_q.size() > 0);
      m_acc = wr_en && (m_q.size() < DEPTH);
      if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (m_pop) begin
        m_w = m_q.pop_front();
        m_b = '1;
        m_b[0] = 1'b0;
        for (int i = 0; i < DW; i++) m_b[1+i] = m_w[i];
        m_nb = 1 + DW;
        if (parity_en) begin
          m_b[m_nb] = parity_type ? ~(^m_w) : (^m_w);
          m_nb++;
        end
        m_nb = m_nb + 1 + (two_stop ? 1 : 0);
        prv_s = cur_s; prv_l = cur_l; prv_b = cur_b;
        cur_s = cyc + 1;
        cur_l = m_nb * CPB;
        cur_b = m_b;
        free_at = cyc + m_nb * CPB;
      end
      if (m_acc) m_q.push_back(wr_data);
    end
  end

  function automatic logic e_tx(int n);
    if (n >= cur_s && n < cur_s + cur_l) return cur_b[(n - cur_s) / CPB];
    if (n >= prv_s && n < prv_s + prv_l) return prv_b[(n - prv_s) / CPB];
    return 1'b1;
  endfunction

  function automatic logic e_busy(int n);
    return (n >= cur_s && n < cur_s + cur_l) || (n >= prv_s && n < prv_s + prv_l);
  endfunction

  function automatic logic e_done(int n);
    return (n == cur_s + cur_l - 1) || (n == prv_s + prv_l - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_3125);
    #1;
    chk("tx", tx, e_tx(cyc));
    chk("busy", busy, e_busy(cyc));
    chk("tx_done", tx_done, e_done(cyc));
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("almost_full", almost_full, m_q.size() >= AFT);
    chk("overflow", overflow, m_ovf);
  end

  // Writes one word into an idle transmitter and pins the serial image to hand-derived bits.
  task automatic send_check(input logic [7:0] d, input logic pe, input logic pt, input logic ts,
                            input logic [0:11] bits, input int nbits, input int lit_len,
                            input logic toggle);
    int busy_n, done_n;
    busy_n = 0;
    done_n = 0;
    @(negedge clk_3125);
    wr_en = 1'b1; wr_data = d; parity_en = pe; parity_type = pt; two_stop = ts;
    @(negedge clk_3125);
    wr_en = 1'b0;
    for (int k = 1; k <= nbits * CPB + 2; k++) begin
      @(posedge clk_3125);
      #1;
      if (k == 1) chk("lat_idle", tx, 1'b1);
      else if (k < 2 + nbits * CPB) chk("lit_bit", tx, bits[(k - 2) / CPB]);
      else chk("lit_after", tx, 1'b1);
      busy_n += busy;
      done_n += tx_done;
      if (toggle && k == 10) begin
        parity_en = ~parity_en;
        two_stop  = ~two_stop;
      end
    end
    chk("lit_len", busy_n, lit_len);
    chk("lit_done", done_n, 1);
  endtask

  int          wr_pct, dones, gaps, lows;
  logic        started;
  logic [0:11] lb;

  initial begin
    repeat (3) @(negedge clk_3125);
    chk("rst_tx", tx, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk_3125);

    lb = 12'b0101_0010_1011;
    send_check(8'hA5, 1'b1, 1'b0, 1'b0, lb, 11, 44, 1'b0);
    repeat (10) @(negedge clk_3125);
    lb = 12'b0100_0000_0011;
    send_check(8'h01, 1'b1, 1'b1, 1'b1, lb, 12, 48, 1'b0);
    repeat (10) @(negedge clk_3125);
    lb = 12'b0111_1111_1111;
    send_check(8'hFF, 1'b0, 1'b0, 1'b0, lb, 10, 40, 1'b1);
    repeat (10) @(negedge clk_3125);

    parity_en = 1'b0; two_stop = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_3125);
      if (i == 17) begin
        chk("full_17", full, 1'b1);
        chk("count_17", count, 16);
      end
      wr_en = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk_3125);
    wr_en = 1'b0;
    chk("ovf_18", overflow, 1'b1);
    chk("count_18", count, 16);
    dones = 0; gaps = 0; started = 1'b0;
    for (int k = 0; k < 17 * 40 + 40; k++) begin
      @(posedge clk_3125);
      #1;
      if (busy) started = 1'b1;
      if (started && dones < 17 && !busy) gaps++;
      dones += tx_done;
    end
    chk("b2b_dones", dones, 17);
    chk("b2b_gaps", gaps, 0);
    @(negedge clk_3125); ovf_clr = 1'b1;
    @(negedge clk_3125); ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 1'b0);

    repeat (20) @(negedge clk_3125);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_3125);
      wr_en = 1'b1;
      wr_data = 8'h55 + 8'(i);
    end
    @(negedge clk_3125);
    wr_en = 1'b0;
    repeat (14) @(negedge clk_3125);
    chk("pre_rst_bit3", tx, 1'b0);
    reset = 1'b0;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_busy", busy, 1'b0);
    repeat (2) @(negedge clk_3125);
    reset = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk_3125);
      #1;
      if (!tx) lows++;
    end
    chk("post_rst_quiet", lows, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk_3125);
      wr_en = 1'b1;
      wr_data = 8'h80 + 8'(i * 7);
    end
    @(negedge clk_3125);
    wr_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 100 && free_at != cyc + 1; k++) @(negedge clk_3125);
      chk("wrap_pre", count, DEPTH - 1);
      wr_en = 1'b1;
      wr_data = 8'hC0 + 8'(r);
      @(negedge clk_3125);
      wr_en = 1'b0;
      chk("wrap_cnt", count, DEPTH - 1);
    end
    repeat (17 * 40 + 20) @(negedge clk_3125);

    wr_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_3125);
      if (i % 500 == 0) wr_pct = $urandom_range(2, 60);
      wr_en       = ($urandom_range(0, 99) < wr_pct);
      wr_data     = 8'($urandom);
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
      two_stop    = 1'($urandom);
      ovf_clr     = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk_3125);
    reset = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0;
    repeat (20 * 48) @(negedge clk_3125);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
